// File: rtl/sw_scan_driver.sv
// sw_scan_driver
//   Converts a 13-bit switch value to four BCD digits with a sequential
//   double-dabble engine and time-multiplexes them onto the display_num
//   inputs (posb/num/dp). Leading zeros are blanked; position 0 always shows.
//
// Ports:
//   CLK      in   1   system clock, rising edge
//   RST      in   1   synchronous active-high reset
//   SW       in  13   binary value to display (0..8191)
//   dp_mask  in   4   decimal-point enable per position
//   posb     out  4   active-low digit select
//   num      out  4   digit code (0-9 or BLANK_CODE)
//   dp       out  1   decimal point for the active position
//   busy     out  1   high while a conversion is running
module sw_scan_driver #(
  parameter int SCAN_DIV   = 5,
  parameter int BLANK_CODE = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [12:0] SW,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  posb,
  output logic [3:0]  num,
  output logic        dp,
  output logic        busy
);

  localparam int         CW    = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
  localparam logic [3:0] BLANK = BLANK_CODE[3:0];

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_reg;
  logic [12:0]    last_sw_reg;
  logic [12:0]    sreg_reg;
  logic [15:0]    bcd_reg;
  logic [3:0]     bit_cnt_reg;
  logic [3:0]     digit_reg [4];
  logic [CW-1:0]  scan_cnt_reg;
  logic [1:0]     pos_reg;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift so
  // that it carries correctly into the next decade.
  logic [15:0] bcd_adj;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 :
                                  bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // blank[k]: digit k and every higher digit are zero. Position 0 never blanks.
  logic [3:0] blank;
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (digit_reg[3] == 4'd0);
    blank[2] = blank[3] && (digit_reg[2] == 4'd0);
    blank[1] = blank[2] && (digit_reg[1] == 4'd0);
  end

  // Conversion FSM. Digits are only written in DONE, so partial shift
  // results never reach the display.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      last_sw_reg <= 13'd0;
      sreg_reg    <= 13'd0;
      bcd_reg     <= 16'd0;
      bit_cnt_reg <= 4'd0;
      busy        <= 1'b0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (SW != last_sw_reg) begin
            sreg_reg    <= SW;
            bcd_reg     <= 16'd0;
            last_sw_reg <= SW;
            bit_cnt_reg <= 4'd0;
            busy        <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_reg, sreg_reg} <= {bcd_adj, sreg_reg} << 1;
          bit_cnt_reg         <= bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd12) state_reg <= DONE;
        end
        DONE: begin
          for (int i = 0; i < 4; i++) digit_reg[i] <= bcd_reg[i*4 +: 4];
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Scan counter and registered display outputs (one cycle behind pos_reg).
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt_reg <= '0;
      pos_reg      <= 2'd0;
      posb         <= 4'b1111;
      num          <= BLANK;
      dp           <= 1'b0;
    end else begin
      if (scan_cnt_reg == CW'(SCAN_DIV)) begin
        scan_cnt_reg <= '0;
        pos_reg      <= pos_reg + 2'd1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + CW'(1);
      end
      posb <= ~(4'b0001 << pos_reg);
      dp   <= dp_mask[pos_reg];
      num  <= blank[pos_reg] ? BLANK : digit_reg[pos_reg];
    end
  end

endmodule
